// File: rtl/counter_read_master_pkg.sv
// counter_rd_pkg: shared types and constants for counter_read_master.
//   rd_state_e     - read sequencer states
//   DefaultDataW   - default counter bus word width
//   TimeoutCntW    - width of the ack timeout counter (covers ACK_TIMEOUT up to 15)
package counter_rd_pkg;

    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned TimeoutCntW  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReqLo,
        StWaitLo,
        StReqHi,
        StWaitHi,
        StDone,
        StAbort
    } rd_state_e;

endpackage

// File: rtl/counter_read_master_if.sv
// counter_read_master_if: req/ack link between the read master and the atomic event counter.
//   req    - access request, one cycle per access
//   atomic - marks the first (low-word) access; only high together with req
//   ack    - counter acknowledge
//   count  - counter word, valid while ack is high
interface counter_read_master_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic              req;
    logic              atomic;
    logic              ack;
    logic [DATA_W-1:0] count;

    modport master (
        output req,
        output atomic,
        input  ack,
        input  count
    );

    modport slave (
        input  req,
        input  atomic,
        output ack,
        output count
    );

endinterface

// File: rtl/counter_read_master_ack_timeout_timer.sv
// ack_timeout_timer: counts wait cycles without an acknowledge.
//   clk       - clock
//   reset     - asynchronous active-low reset
//   clear_i   - zero the count
//   enable_i  - a wait cycle without ack; advances the count
//   expired_o - this enabled cycle is the ACK_TIMEOUT-th consecutive one
module ack_timeout_timer
    import counter_rd_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TimeoutCntW-1:0] LastCnt = TimeoutCntW'(ACK_TIMEOUT - 1);

    logic [TimeoutCntW-1:0] cnt_q, cnt_d;

    // Expiry is decided in the same cycle so the FSM leaves WAIT after exactly
    // ACK_TIMEOUT ack-less cycles.
    assign expired_o = enable_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_read_master.sv
// counter_read_master: turns one 64-bit read command into two 32-bit accesses to the
// atomic event counter (low word with the atomic marker, then the saved high word) and
// returns the concatenated result.
//   clk        - clock
//   reset      - asynchronous active-low reset
//   rd_start_i - read command, accepted only when idle
//   rd_busy_o  - read in progress
//   rd_valid_o - one-cycle pulse, rd_data_o holds a new value
//   rd_data_o  - last assembled {high word, low word}, held between reads
//   rd_err_o   - one-cycle pulse, read aborted on ack timeout
//   bus        - req/atomic/ack/count link to the counter
module counter_read_master
    import counter_rd_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter int unsigned DATA_W      = DefaultDataW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_start_i,
    output logic                  rd_busy_o,
    output logic                  rd_valid_o,
    output logic [2*DATA_W-1:0]   rd_data_o,
    output logic                  rd_err_o,
    counter_read_master_if.master bus
);

    rd_state_e             state_q, state_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [2*DATA_W-1:0]   data_q, data_d;
    logic                  req_q, req_d;
    logic                  atomic_q, atomic_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic in_req, in_wait, expired;

    assign in_req  = (state_q == StReqLo) || (state_q == StReqHi);
    assign in_wait = (state_q == StWaitLo) || (state_q == StWaitHi);

    ack_timeout_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (in_req),
        .enable_i  (in_wait && !bus.ack),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle:   if (rd_start_i) state_d = StReqLo;
            StReqLo:  state_d = StWaitLo;
            StWaitLo: begin
                if (bus.ack) begin
                    lo_d    = bus.count;
                    state_d = StReqHi;
                end else if (expired) begin
                    state_d = StAbort;
                end
            end
            StReqHi:  state_d = StWaitHi;
            StWaitHi: begin
                // The result register loads on the way into DONE so the new value
                // appears in the same cycle as the valid pulse.
                if (bus.ack) begin
                    data_d  = {bus.count, lo_q};
                    state_d = StDone;
                end else if (expired) begin
                    state_d = StAbort;
                end
            end
            StDone:   state_d = StIdle;
            StAbort:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        req_d    = (state_d == StReqLo) || (state_d == StReqHi);
        atomic_d = (state_d == StReqLo);
        busy_d   = (state_d != StIdle);
        valid_d  = (state_d == StDone);
        err_d    = (state_d == StAbort);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            data_q   <= '0;
            req_q    <= 1'b0;
            atomic_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            data_q   <= data_d;
            req_q    <= req_d;
            atomic_q <= atomic_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bus.req    = req_q;
    assign bus.atomic = atomic_q;
    assign rd_busy_o  = busy_q;
    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;
    assign rd_err_o   = err_q;

endmodule
